accel_mem_port: RTL and testbench
=================================

ACCEL_MEM_PORT -- requirements
Module: accel_mem_port

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset: clk (in, 1) rising-edge clock; reset (in, 1) synchronous, active-high.
REQ-002 SHALL provide the accelerator-side responder ports:
  - mem_read (in, 1): word read request, held until mem_resp.
  - mem_write (in, 1): word write request, held until mem_resp.
  - address (in, 32): byte address; [1:0] ignored.
  - st_data (in, 32): write data.
  - mem_resp (out, 1): one-cycle completion pulse.
  - data (out, 32): read data, valid while mem_resp=1.
REQ-003 SHALL provide the physical-memory initiator ports:
  - pmem_read (out, 1) and pmem_write (out, 1): line requests, held until pmem_resp.
  - pmem_address (out, 32): line address, [4:0]=0.
  - pmem_wdata (out, 256) and pmem_rdata (in, 256): line write/read data.
  - pmem_resp (in, 1): line completion.

Function
REQ-004 SHALL hold one 256-bit line buffer (8 words) with tag = address[31:5], a valid bit and a dirty bit; address[4:2] selects the word.
REQ-005 SHALL run the FSM IDLE, RESP, WB, FETCH; all transitions occur on clk.
REQ-006 In IDLE with a request and a hit (valid and tag match), SHALL go to RESP; mem_resp=1 for exactly that one cycle, then return to IDLE. Hit latency is 1 cycle from request sample to mem_resp.
REQ-007 A write hit SHALL update the selected word and set dirty on the IDLE->RESP edge; a read hit SHALL drive data = selected word during RESP.
REQ-008 On a miss with dirty=1, SHALL go to WB: pmem_write=1, pmem_address={old tag,5'b0}, pmem_wdata=buffer, held until pmem_resp. On pmem_resp, SHALL clear dirty and go to FETCH.
REQ-009 On a miss with dirty=0 or valid=0, SHALL go directly to FETCH.
REQ-010 In FETCH, SHALL drive pmem_read=1 and pmem_address={address[31:5],5'b0}, held until pmem_resp. On pmem_resp, SHALL load pmem_rdata, set valid, load the tag, and return to IDLE, where the request is re-evaluated as a hit.
REQ-011 SHALL never assert pmem_read and pmem_write together; both SHALL be 0 outside WB/FETCH.
REQ-012 SHALL ignore requests in the cycle immediately after RESP. This tolerates the requester's one-cycle request drop after a response; no back-to-back mem_resp pulses are permitted.
REQ-013 If mem_read and mem_write are both 1, SHALL treat the request as a write.
REQ-014 A request that changes address while in WB/FETCH is a protocol violation; behaviour is unspecified and need not be checked.
REQ-015 data SHALL be 0 whenever mem_resp=0.

Reset
REQ-016 On reset, SHALL set: state=IDLE, valid=0, dirty=0, mem_resp=0, pmem_read=0, pmem_write=0, flush_done=0. The buffer contents and tag are not reset.
REQ-017 Reset mid-WB/FETCH SHALL abandon the pmem transaction immediately (strobes low next cycle). Dirty data is lost.

Configuration
REQ-018 Macro ACCEL_MEM_FLUSH_EN, when defined, SHALL add:
  - flush (in, 1): flush request pulse or level.
  - flush_done (out, 1): one-cycle completion pulse.
  - a FLUSH state.
REQ-019 With ACCEL_MEM_FLUSH_EN defined:
  - flush SHALL be sampled in IDLE only when no request is present; requests win ties.
  - If dirty=1, SHALL run a WB-style line write in FLUSH, clear dirty, and pulse flush_done the cycle after pmem_resp.
  - Otherwise SHALL pulse flush_done the next cycle.
  - valid is kept.
REQ-020 Without ACCEL_MEM_FLUSH_EN, the ports flush/flush_done and the FLUSH state SHALL be absent; dirty data is written back only on eviction.

Structure
REQ-021 SHALL place in package rv32i_types: the FSM state enum and the constants LINE_BITS=256, LINE_WORDS=8, OFFSET_BITS=5.
REQ-022 SHALL implement the data line in sub-module accel_line_buf, which provides 256-bit line load, 32-bit word write with word index, and word read mux. The FSM, tag, valid and dirty stay in accel_mem_port.

Verification
REQ-023 Cold read: reset; read 0x1000_0004; pmem_rdata word1=0xDEADBEEF; pmem_resp after 3 cycles.
  - Required: exactly one FETCH at 0x1000_0000; one mem_resp with data=0xDEADBEEF.
REQ-024 Write hit: after REQ-023, write 0x1000_0008 with st_data=0x12345678, then read 0x1000_0008.
  - Required: each mem_resp 1 cycle after request; read returns 0x12345678; no pmem activity.
REQ-025 Dirty eviction: after REQ-024, read 0x2000_0000.
  - Required: WB at 0x1000_0000 whose pmem_wdata word2=0x12345678, then FETCH at 0x2000_0000; pmem_read/pmem_write never both high.
REQ-026 Requester drop: 16 sequential writes 0x3000_0000..0x3000_003C, each request dropped for one cycle after its mem_resp.
  - Required: 16 mem_resp pulses; no two in adjacent cycles; WB at 0x3000_0000 when the 0x3000_0020 line is fetched.
REQ-027 Reset in FETCH: assert reset while pmem_read=1.
  - Required: pmem_read=0 next cycle; valid=0; a following read to the same address refetches.
REQ-028 Flush (ACCEL_MEM_FLUSH_EN): dirty line at 0x4000_0000, pulse flush.
  - Required: one pmem_write at 0x4000_0000 and flush_done 1 cycle after pmem_resp.
  - Required: a second flush gives flush_done next cycle with no pmem_write.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types and line geometry for the accelerator memory port.
// The FLUSH state exists only when ACCEL_MEM_FLUSH_EN is defined.
package rv32i_types;
   localparam int LINE_BITS   = 256;
   localparam int LINE_WORDS  = 8;
   localparam int OFFSET_BITS = 5;
   localparam int WORD_BITS   = 32;
   localparam int IDX_BITS    = 3;
   localparam int TAG_BITS    = 32 - OFFSET_BITS;

   typedef enum logic [2:0] {
      IDLE,
      RESP,
      WB,
      FETCH
`ifdef ACCEL_MEM_FLUSH_EN
      ,
      FLUSH
`endif
   } state_t;

   function automatic logic [31:0] line_addr(input logic [TAG_BITS-1:0] tag);
      return {tag, {OFFSET_BITS{1'b0}}};
   endfunction
endpackage

// File: rtl/accel_mem_port_line_buf.sv
// Single 256-bit line store: whole-line load, indexed word write, word read mux.
// Line contents are deliberately not reset.
module accel_line_buf
   import rv32i_types::*;
(
   input  logic                 clk,
   input  logic                 load,
   input  logic [LINE_BITS-1:0] load_line,
   input  logic                 wr_en,
   input  logic [IDX_BITS-1:0]  wr_idx,
   input  logic [WORD_BITS-1:0] wr_word,
   input  logic [IDX_BITS-1:0]  rd_idx,
   output logic [LINE_BITS-1:0] line,
   output logic [WORD_BITS-1:0] rd_word
);
   logic [LINE_BITS-1:0] line_reg;
   logic [WORD_BITS-1:0] words [LINE_WORDS];

   // A fill always wins over a word write; the FSM never requests both.
   always_ff @(posedge clk) begin
      if (load)
         line_reg <= load_line;
      else if (wr_en)
         line_reg[{wr_idx, 5'd0} +: WORD_BITS] <= wr_word;
   end

   genvar gi;
   generate
      for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
         assign words[gi] = line_reg[gi*WORD_BITS +: WORD_BITS];
      end
   endgenerate

   assign line    = line_reg;
   assign rd_word = words[rd_idx];
endmodule

// File: rtl/accel_mem_port.sv
// One-line write-back buffer between an accelerator word port and a 256-bit pmem.
// Define ACCEL_MEM_FLUSH_EN to add the flush/flush_done ports and the FLUSH state.
module accel_mem_port
   import rv32i_types::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic [31:0]          address,
   input  logic [31:0]          st_data,
   output logic                 mem_resp,
   output logic [31:0]          data,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output logic [31:0]          pmem_address,
   output logic [LINE_BITS-1:0] pmem_wdata,
   input  logic [LINE_BITS-1:0] pmem_rdata,
   input  logic                 pmem_resp
`ifdef ACCEL_MEM_FLUSH_EN
   ,
   input  logic                 flush,
   output logic                 flush_done
`endif
);
   state_t               state_reg;
   logic [TAG_BITS-1:0]  tag_reg;
   logic                 valid_reg;
   logic                 dirty_reg;
   logic                 skip_reg;
   logic                 mem_resp_reg;
   logic [31:0]          data_reg;
   logic                 pmem_read_reg;
   logic                 pmem_write_reg;
   logic [31:0]          pmem_address_reg;
`ifdef ACCEL_MEM_FLUSH_EN
   logic                 flush_done_reg;
`endif

   logic                 req;
   logic                 hit;
   logic                 line_load;
   logic                 word_wr;
   logic [IDX_BITS-1:0]  word_idx;
   logic [31:0]          rd_word;
   logic [LINE_BITS-1:0] line;

   // Byte offset bits take no part in the access; they are folded away here.
   assign req      = (mem_read | mem_write) | (1'b0 & (^address[1:0]));
   assign hit      = valid_reg && (tag_reg == address[31:OFFSET_BITS]);
   assign word_idx = address[OFFSET_BITS-1:2];

   assign line_load = !reset && (state_reg == FETCH) && pmem_resp;
   assign word_wr   = !reset && (state_reg == IDLE) && !skip_reg && mem_write && hit;

   accel_line_buf u_line_buf (
      .clk       (clk),
      .load      (line_load),
      .load_line (pmem_rdata),
      .wr_en     (word_wr),
      .wr_idx    (word_idx),
      .wr_word   (st_data),
      .rd_idx    (word_idx),
      .line      (line),
      .rd_word   (rd_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         valid_reg      <= 1'b0;
         dirty_reg      <= 1'b0;
         skip_reg       <= 1'b0;
         mem_resp_reg   <= 1'b0;
         data_reg       <= '0;
         pmem_read_reg  <= 1'b0;
         pmem_write_reg <= 1'b0;
`ifdef ACCEL_MEM_FLUSH_EN
         flush_done_reg <= 1'b0;
`endif
      end else begin
         mem_resp_reg <= 1'b0;
         data_reg     <= '0;
         skip_reg     <= 1'b0;
`ifdef ACCEL_MEM_FLUSH_EN
         flush_done_reg <= 1'b0;
`endif
         case (state_reg)
            IDLE: begin
               // skip_reg masks the stale request still held right after a response.
               if (req && !skip_reg) begin
                  if (hit) begin
                     state_reg    <= RESP;
                     mem_resp_reg <= 1'b1;
                     data_reg     <= mem_write ? st_data : rd_word;
                     if (mem_write)
                        dirty_reg <= 1'b1;
                  end else if (dirty_reg) begin
                     state_reg        <= WB;
                     pmem_write_reg   <= 1'b1;
                     pmem_address_reg <= line_addr(tag_reg);
                  end else begin
                     state_reg        <= FETCH;
                     pmem_read_reg    <= 1'b1;
                     pmem_address_reg <= line_addr(address[31:OFFSET_BITS]);
                  end
               end
`ifdef ACCEL_MEM_FLUSH_EN
               else if (!req && flush) begin
                  if (dirty_reg) begin
                     state_reg        <= FLUSH;
                     pmem_write_reg   <= 1'b1;
                     pmem_address_reg <= line_addr(tag_reg);
                  end else begin
                     flush_done_reg <= 1'b1;
                  end
               end
`endif
            end
            RESP: begin
               state_reg <= IDLE;
               skip_reg  <= 1'b1;
            end
            WB: begin
               if (pmem_resp) begin
                  state_reg        <= FETCH;
                  dirty_reg        <= 1'b0;
                  pmem_write_reg   <= 1'b0;
                  pmem_read_reg    <= 1'b1;
                  pmem_address_reg <= line_addr(address[31:OFFSET_BITS]);
               end
            end
            FETCH: begin
               if (pmem_resp) begin
                  state_reg     <= IDLE;
                  pmem_read_reg <= 1'b0;
                  valid_reg     <= 1'b1;
                  tag_reg       <= address[31:OFFSET_BITS];
               end
            end
`ifdef ACCEL_MEM_FLUSH_EN
            FLUSH: begin
               if (pmem_resp) begin
                  state_reg      <= IDLE;
                  pmem_write_reg <= 1'b0;
                  dirty_reg      <= 1'b0;
                  flush_done_reg <= 1'b1;
               end
            end
`endif
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign mem_resp     = mem_resp_reg;
   assign data         = data_reg;
   assign pmem_read    = pmem_read_reg;
   assign pmem_write   = pmem_write_reg;
   assign pmem_address = pmem_address_reg;
   assign pmem_wdata   = line;
`ifdef ACCEL_MEM_FLUSH_EN
   assign flush_done   = flush_done_reg;
`endif
endmodule

// File: tb/tb_accel_mem_port.sv
// Directed bench for accel_mem_port with a 3-cycle pmem responder and transaction log.
// Flush steps are compiled in only when ACCEL_MEM_FLUSH_EN is defined.
module tb_accel_mem_port;
   logic         clk = 1'b0;
   logic         reset;
   logic         mem_read, mem_write;
   logic [31:0]  address, st_data;
   logic         mem_resp;
   logic [31:0]  data;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata, pmem_rdata;
   logic         pmem_resp;
`ifdef ACCEL_MEM_FLUSH_EN
   logic         flush, flush_done;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [255:0] fill_line = '0;
   int           pm_cnt    = 0;
   int           n_ops     = 0;
   int           both_cnt  = 0;
   int           resp_cnt  = 0;
   int           adj_cnt   = 0;
   int           data_nz   = 0;
   logic         prev_resp = 1'b0;
   logic         op_wr    [64];
   logic [31:0]  op_addr  [64];
   logic [255:0] op_wdata [64];

   always #5 clk = ~clk;

   accel_mem_port dut (
      .clk          (clk),
      .reset        (reset),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .address      (address),
      .st_data      (st_data),
      .mem_resp     (mem_resp),
      .data         (data),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
`ifdef ACCEL_MEM_FLUSH_EN
      ,
      .flush        (flush),
      .flush_done   (flush_done)
`endif
   );

   // pmem model: responds on the third cycle a strobe is seen, logs every line transfer.
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (pmem_read && pmem_write) both_cnt++;
         if (mem_resp) begin
            resp_cnt++;
            if (prev_resp) adj_cnt++;
         end else if (data !== 32'h0) begin
            data_nz++;
         end
         prev_resp = mem_resp;
         if (reset || pmem_resp || !(pmem_read || pmem_write)) begin
            pmem_resp = 1'b0;
            pm_cnt    = 0;
         end else begin
            pm_cnt++;
            if (pm_cnt == 3) begin
               pmem_resp  = 1'b1;
               pmem_rdata = fill_line;
               if (n_ops < 64) begin
                  op_wr[n_ops]    = pmem_write;
                  op_addr[n_ops]  = pmem_address;
                  op_wdata[n_ops] = pmem_wdata;
               end
               n_ops++;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request, keep it up through the cycle after mem_resp, then drop it one cycle.
   task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] sd, output logic [31:0] got, output int lat);
      mem_read  = rd;
      mem_write = wr;
      address   = a;
      st_data   = sd;
      got       = '0;
      lat       = 0;
      while (lat < 60) begin
         @(negedge clk);
         lat++;
         if (mem_resp) begin
            got = data;
            break;
         end
      end
      $display("[TB] req rd=%0b wr=%0b addr=%h sd=%h -> data=%h lat=%0d", rd, wr, a, sd, got, lat);
      repeat (2) @(negedge clk);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
   endtask

   task automatic set_fill(input logic [31:0] base);
      for (int i = 0; i < 8; i++) fill_line[i*32 +: 32] = base + 32'(i);
   endtask

   logic [31:0] got;
   int          lat;
   int          b;
   int          r0;
   logic        found;

   initial begin
      reset     = 1'b1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      address   = '0;
      st_data   = '0;
`ifdef ACCEL_MEM_FLUSH_EN
      flush     = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_mem_resp", {31'b0, mem_resp}, 32'h0);
      chk("rst_pmem_read", {31'b0, pmem_read}, 32'h0);
      chk("rst_pmem_write", {31'b0, pmem_write}, 32'h0);
      chk("rst_data", data, 32'h0);
      chk("rst_valid", {31'b0, dut.valid_reg}, 32'h0);
`ifdef ACCEL_MEM_FLUSH_EN
      chk("rst_flush_done", {31'b0, flush_done}, 32'h0);
`endif
      reset = 1'b0;
      @(negedge clk);

      // Cold read: clean miss, single fetch, 3-cycle pmem then re-evaluated hit.
      set_fill(32'h1111_0000);
      fill_line[63:32] = 32'hDEAD_BEEF;
      b = n_ops;
      do_req(1'b1, 1'b0, 32'h1000_0004, 32'h0, got, lat);
      chk("cold_data", got, 32'hDEAD_BEEF);
      chk("cold_lat", lat, 5);
      chk("cold_nops", n_ops - b, 1);
      chk("cold_op_wr", {31'b0, op_wr[b]}, 32'h0);
      chk("cold_op_addr", op_addr[b], 32'h1000_0000);

      // Write hit then read-back, both one-cycle hits with no pmem traffic.
      b = n_ops;
      do_req(1'b0, 1'b1, 32'h1000_0008, 32'h1234_5678, got, lat);
      chk("wrhit_lat", lat, 1);
      do_req(1'b1, 1'b0, 32'h1000_0008, 32'h0, got, lat);
      chk("rdhit_lat", lat, 1);
      chk("rdhit_data", got, 32'h1234_5678);
      do_req(1'b1, 1'b0, 32'h1000_0004, 32'h0, got, lat);
      chk("rdhit_word1", got, 32'hDEAD_BEEF);
      chk("hit_nops", n_ops - b, 0);

      // Dirty eviction: write-back of old line, then fetch of the new one.
      set_fill(32'h2222_0000);
      b = n_ops;
      do_req(1'b1, 1'b0, 32'h2000_0000, 32'h0, got, lat);
      chk("evict_data", got, 32'h2222_0000);
      chk("evict_lat", lat, 9);
      chk("evict_nops", n_ops - b, 2);
      chk("evict_wb_wr", {31'b0, op_wr[b]}, 32'h1);
      chk("evict_wb_addr", op_addr[b], 32'h1000_0000);
      chk("evict_wb_w2", op_wdata[b][95:64], 32'h1234_5678);
      chk("evict_wb_w1", op_wdata[b][63:32], 32'hDEAD_BEEF);
      chk("evict_fe_wr", {31'b0, op_wr[b+1]}, 32'h0);
      chk("evict_fe_addr", op_addr[b+1], 32'h2000_0000);

      // Sixteen sequential writes across two lines with the requester drop.
      set_fill(32'h3333_0000);
      b  = n_ops;
      r0 = resp_cnt;
      for (int k = 0; k < 16; k++)
         do_req(1'b0, 1'b1, 32'h3000_0000 + 32'(4*k), 32'hA000_0000 + 32'(k), got, lat);
      chk("seq_resp_cnt", resp_cnt - r0, 16);
      chk("seq_nops", n_ops - b, 3);
      chk("seq_fe0_addr", op_addr[b], 32'h3000_0000);
      chk("seq_wb_wr", {31'b0, op_wr[b+1]}, 32'h1);
      chk("seq_wb_addr", op_addr[b+1], 32'h3000_0000);
      chk("seq_wb_w0", op_wdata[b+1][31:0], 32'hA000_0000);
      chk("seq_wb_w7", op_wdata[b+1][255:224], 32'hA000_0007);
      chk("seq_fe1_addr", op_addr[b+2], 32'h3000_0020);
      do_req(1'b1, 1'b0, 32'h3000_0024, 32'h0, got, lat);
      chk("seq_readback", got, 32'hA000_0009);
      chk("seq_readback_lat", lat, 1);
      // Both strobes set means a read-and-write request behaves as a write.
      do_req(1'b1, 1'b1, 32'h3000_0028, 32'h5A5A_5A5A, got, lat);
      do_req(1'b1, 1'b0, 32'h3000_0028, 32'h0, got, lat);
      chk("rw_tie_write", got, 32'h5A5A_5A5A);

      // Reset while the line fetch is outstanding.
      set_fill(32'h5555_0000);
      mem_read = 1'b1;
      address  = 32'h5000_0000;
      found    = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         if (pmem_read) found = 1'b1;
      end
      chk("rstf_fetch_seen", {31'b0, found}, 32'h1);
      reset    = 1'b1;
      mem_read = 1'b0;
      @(negedge clk);
      chk("rstf_pmem_read", {31'b0, pmem_read}, 32'h0);
      chk("rstf_pmem_write", {31'b0, pmem_write}, 32'h0);
      chk("rstf_valid", {31'b0, dut.valid_reg}, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      b = n_ops;
      do_req(1'b1, 1'b0, 32'h5000_0000, 32'h0, got, lat);
      chk("rstf_refetch_data", got, 32'h5555_0000);
      chk("rstf_refetch_lat", lat, 5);
      chk("rstf_nops", n_ops - b, 1);
      chk("rstf_op_addr", op_addr[b], 32'h5000_0000);
      chk("rstf_op_wr", {31'b0, op_wr[b]}, 32'h0);

`ifdef ACCEL_MEM_FLUSH_EN
      // Flush of a dirty line, then a flush with nothing to write.
      set_fill(32'h4444_0000);
      do_req(1'b0, 1'b1, 32'h4000_0000, 32'h0BAD_F00D, got, lat);
      b     = n_ops;
      flush = 1'b1;
      lat   = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         flush = 1'b0;
         if (flush_done) break;
      end
      $display("[TB] flush dirty -> lat=%0d ops=%0d", lat, n_ops - b);
      chk("flush1_lat", lat, 4);
      chk("flush1_nops", n_ops - b, 1);
      chk("flush1_wr", {31'b0, op_wr[b]}, 32'h1);
      chk("flush1_addr", op_addr[b], 32'h4000_0000);
      chk("flush1_w0", op_wdata[b][31:0], 32'h0BAD_F00D);
      @(negedge clk);
      chk("flush1_pulse_end", {31'b0, flush_done}, 32'h0);
      b     = n_ops;
      flush = 1'b1;
      lat   = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         flush = 1'b0;
         if (flush_done) break;
      end
      $display("[TB] flush clean -> lat=%0d ops=%0d", lat, n_ops - b);
      chk("flush2_lat", lat, 1);
      chk("flush2_nops", n_ops - b, 0);
      do_req(1'b1, 1'b0, 32'h4000_0000, 32'h0, got, lat);
      chk("flush_valid_kept", lat, 1);
`endif

      chk("never_both_strobes", both_cnt, 0);
      chk("no_adjacent_resp", adj_cnt, 0);
      chk("data_zero_idle", data_nz, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
